// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_ctrl_pkg : shared types for the burst SRAM controller
// Rev 1.0
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_READ     = 3'd2,
        ST_RD_DRAIN = 3'd3,
        ST_WR_RESP  = 3'd4
    } state_t;

    // Travels alongside each memory read so its data can be flagged on return
    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// mem_rd_tag_pipe : RD_LAT-deep delay line of read tags
// Rev 1.0
// ============================================================================
module mem_rd_tag_pipe
    import mem_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t r_stage [RD_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign tag_out = r_stage[RD_LAT-1];

endmodule : mem_rd_tag_pipe
`default_nettype wire

// File: rtl/mem_ctrl_burst.sv
`default_nettype none
// ============================================================================
// mem_ctrl_burst : single-port SRAM controller with incrementing bursts
// Rev 1.0
// ============================================================================
module mem_ctrl_burst
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 2,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_sys,
    output logic              cmd_ready_sys,
    input  logic              we_sys,
    input  logic [ADDR_W-1:0] addr_sys,
    input  logic [LEN_W-1:0]  len_sys,
    input  logic              wvalid_sys,
    output logic              wready_sys,
    input  logic [DATA_W-1:0] wdata_sys,
    output logic              wr_done_sys,
    output logic              rvalid_sys,
    output logic [DATA_W-1:0] rdata_sys,
    output logic              rlast_sys,
    output logic              ce_mem,
    output logic              we_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] datai_mem,
    input  logic [DATA_W-1:0] datao_mem
);

    localparam int CNT_W = LEN_W + 1;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

    logic                r_ce, w_ce_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_addr_mem, w_addr_mem_nxt;
    logic [DATA_W-1:0]   r_datai, w_datai_nxt;
    logic                r_rd_last, w_rd_last_nxt;
    logic                r_wr_done, w_wr_done_nxt;

    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rlast;

    rd_tag_t             w_tag_in, w_tag_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory-pin values are computed here and registered below, so every
    // pin changes only on a clock edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_cnt_nxt      = r_cnt;
        w_ce_nxt       = 1'b0;
        w_we_nxt       = 1'b0;
        w_addr_mem_nxt = '0;
        w_datai_nxt    = '0;
        w_rd_last_nxt  = 1'b0;
        w_wr_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_sys) begin
                    if (we_sys) begin
                        w_state_nxt = ST_WRITE;
                        w_addr_nxt  = addr_sys;
                        w_cnt_nxt   = {1'b0, len_sys} + CNT_W'(1);
                    end else begin
                        // First read goes out with the handshake so reads land in cycles 1..N
                        w_state_nxt    = ST_READ;
                        w_ce_nxt       = 1'b1;
                        w_addr_mem_nxt = addr_sys;
                        w_rd_last_nxt  = (len_sys == '0);
                        w_addr_nxt     = addr_sys + ADDR_W'(1);
                        w_cnt_nxt      = {1'b0, len_sys};
                    end
                end
            end

            ST_WRITE: begin
                if (wvalid_sys) begin
                    w_ce_nxt       = 1'b1;
                    w_we_nxt       = 1'b1;
                    w_addr_mem_nxt = r_addr;
                    w_datai_nxt    = wdata_sys;
                    w_addr_nxt     = r_addr + ADDR_W'(1);
                    w_cnt_nxt      = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_wr_done_nxt = 1'b1;
                        w_state_nxt   = ST_WR_RESP;
                    end
                end
            end

            ST_WR_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            ST_READ: begin
                // r_cnt counts reads still to issue after the one sent from IDLE
                if (r_cnt != '0) begin
                    w_ce_nxt       = 1'b1;
                    w_addr_mem_nxt = r_addr;
                    w_rd_last_nxt  = (r_cnt == CNT_W'(1));
                    w_addr_nxt     = r_addr + ADDR_W'(1);
                    w_cnt_nxt      = r_cnt - CNT_W'(1);
                end
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_RD_DRAIN;
                end
            end

            ST_RD_DRAIN: begin
                if (r_rlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_cnt      <= '0;
            r_ce       <= 1'b0;
            r_we       <= 1'b0;
            r_addr_mem <= '0;
            r_datai    <= '0;
            r_rd_last  <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rlast    <= 1'b0;
        end else begin
            r_addr     <= w_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ce       <= w_ce_nxt;
            r_we       <= w_we_nxt;
            r_addr_mem <= w_addr_mem_nxt;
            r_datai    <= w_datai_nxt;
            r_rd_last  <= w_rd_last_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_rvalid   <= w_tag_out.valid;
            r_rlast    <= w_tag_out.valid & w_tag_out.last;
            if (w_tag_out.valid) begin
                r_rdata <= datao_mem;
            end
        end
    end

    // Tag enters the line while its read is on the pins, so it exits in the
    // cycle the memory presents that read's data.
    assign w_tag_in.valid = r_ce & ~r_we;
    assign w_tag_in.last  = r_rd_last;

    mem_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (w_tag_in),
        .tag_out (w_tag_out)
    );

    assign cmd_ready_sys = (r_state == ST_IDLE);
    assign wready_sys    = (r_state == ST_WRITE);
    assign wr_done_sys   = r_wr_done;
    assign rvalid_sys    = r_rvalid;
    assign rdata_sys     = r_rdata;
    assign rlast_sys     = r_rlast;
    assign ce_mem        = r_ce;
    assign we_mem        = r_we;
    assign addr_mem      = r_addr_mem;
    assign datai_mem     = r_datai;

endmodule : mem_ctrl_burst
`default_nettype wire

// File: tb/tb_mem_ctrl_burst.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl_burst : directed bench, RD_LAT=1 and RD_LAT=3 controllers
// Rev 1.0
// ============================================================================
module tb_mem_ctrl_burst;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Controller with RD_LAT=1
    logic       reset1, cmd_valid, we, wvalid;
    logic [7:0] addr, wdata;
    logic [1:0] len;
    logic       cmd_ready, wready, wr_done, rvalid, rlast, ce, mwe;
    logic [7:0] rdata, maddr, mdatai, mdatao;

    // Controller with RD_LAT=3 (read-only use)
    logic       reset3, cmd_valid3, we3, wvalid3;
    logic [7:0] addr3, wdata3;
    logic [1:0] len3;
    logic       cmd_ready3, wready3, wr_done3, rvalid3, rlast3, ce3, mwe3;
    logic [7:0] rdata3, maddr3, mdatai3, mdatao3;

    mem_ctrl_burst #(.ADDR_W(8), .DATA_W(8), .LEN_W(2), .RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset1),
        .cmd_valid_sys(cmd_valid), .cmd_ready_sys(cmd_ready), .we_sys(we),
        .addr_sys(addr), .len_sys(len),
        .wvalid_sys(wvalid), .wready_sys(wready), .wdata_sys(wdata),
        .wr_done_sys(wr_done), .rvalid_sys(rvalid), .rdata_sys(rdata), .rlast_sys(rlast),
        .ce_mem(ce), .we_mem(mwe), .addr_mem(maddr), .datai_mem(mdatai), .datao_mem(mdatao)
    );

    mem_ctrl_burst #(.ADDR_W(8), .DATA_W(8), .LEN_W(2), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset3),
        .cmd_valid_sys(cmd_valid3), .cmd_ready_sys(cmd_ready3), .we_sys(we3),
        .addr_sys(addr3), .len_sys(len3),
        .wvalid_sys(wvalid3), .wready_sys(wready3), .wdata_sys(wdata3),
        .wr_done_sys(wr_done3), .rvalid_sys(rvalid3), .rdata_sys(rdata3), .rlast_sys(rlast3),
        .ce_mem(ce3), .we_mem(mwe3), .addr_mem(maddr3), .datai_mem(mdatai3), .datao_mem(mdatao3)
    );

    // Synchronous memories; 8'hEE is returned for cycles without a read
    logic [7:0] mem1 [256];
    logic [7:0] rd1;
    always @(posedge clk) begin
        if (ce && mwe) mem1[maddr] <= mdatai;
        rd1 <= (ce && !mwe) ? mem1[maddr] : 8'hEE;
    end
    assign mdatao = rd1;

    logic [7:0] mem3 [256];
    logic [7:0] rd3_p [3];
    always @(posedge clk) begin
        rd3_p[0] <= (ce3 && !mwe3) ? mem3[maddr3] : 8'hEE;
        rd3_p[1] <= rd3_p[0];
        rd3_p[2] <= rd3_p[1];
    end
    assign mdatao3 = rd3_p[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back write burst used to preload memory through the controller
    task automatic dut_write(input logic [7:0] a, input logic [1:0] l,
                             input logic [7:0] d0, input logic [7:0] step);
        logic [7:0] d;
        int guard;
        d = d0;
        cmd_valid = 1'b1; we = 1'b1; addr = a; len = l;
        tick();
        cmd_valid = 1'b0; we = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            wvalid = 1'b1; wdata = d;
            d = d + step;
            tick();
        end
        wvalid = 1'b0;
        guard = 0;
        while (!cmd_ready && guard < 10) begin
            tick();
            guard++;
        end
        check_eq("preload_idle", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int         seen, sent, nrv;
        logic [7:0] wv_tab;
        logic [7:0] ea;

        for (int i = 0; i < 4; i++) mem3[8'h50 + 8'(i)] = 8'hC1 + 8'(i);
        reset1 = 1'b1; cmd_valid = 1'b0; we = 1'b0; addr = '0; len = '0; wvalid = 1'b0; wdata = '0;
        reset3 = 1'b1; cmd_valid3 = 1'b0; we3 = 1'b0; addr3 = '0; len3 = '0; wvalid3 = 1'b0; wdata3 = '0;
        repeat (3) tick();

        check_eq("rst ce", 32'(ce), 32'd0);
        check_eq("rst addr_mem", 32'(maddr), 32'd0);
        check_eq("rst rvalid", 32'(rvalid), 32'd0);
        check_eq("rst rdata", 32'(rdata), 32'd0);
        check_eq("rst wr_done", 32'(wr_done), 32'd0);
        check_eq("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst wready", 32'(wready), 32'd0);
        reset1 = 1'b0; reset3 = 1'b0;
        tick();

        // Single write
        cmd_valid = 1'b1; we = 1'b1; addr = 8'h10; len = 2'd0;
        tick();
        check_eq("w1 c1 wready", 32'(wready), 32'd1);
        check_eq("w1 c1 cmd_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0; wvalid = 1'b1; wdata = 8'hA5;
        tick();
        check_eq("w1 c2 ce", 32'(ce), 32'd1);
        check_eq("w1 c2 we_mem", 32'(mwe), 32'd1);
        check_eq("w1 c2 addr_mem", 32'(maddr), 32'h10);
        check_eq("w1 c2 datai", 32'(mdatai), 32'hA5);
        check_eq("w1 c2 wr_done", 32'(wr_done), 32'd1);
        wvalid = 1'b0;
        tick();
        check_eq("w1 c3 cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("w1 c3 wr_done", 32'(wr_done), 32'd0);
        check_eq("w1 c3 ce", 32'(ce), 32'd0);

        // Read burst, RD_LAT=1
        dut_write(8'h20, 2'd3, 8'h11, 8'h11);
        cmd_valid = 1'b1; we = 1'b0; addr = 8'h20; len = 2'd3;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            check_eq($sformatf("rd c%0d ce", c), 32'(ce), 32'(c <= 4));
            check_eq($sformatf("rd c%0d addr_mem", c), 32'(maddr), (c <= 4) ? 32'(8'h1F + 8'(c)) : 32'd0);
            check_eq($sformatf("rd c%0d rvalid", c), 32'(rvalid), 32'(c >= 3 && c <= 6));
            check_eq($sformatf("rd c%0d rdata", c), 32'(rdata),
                     (c < 3) ? 32'd0 : (c <= 6) ? 32'(8'h11 * 8'(c - 2)) : 32'h44);
            check_eq($sformatf("rd c%0d rlast", c), 32'(rlast), 32'(c == 6));
            check_eq($sformatf("rd c%0d cmd_ready", c), 32'(cmd_ready), 32'(c == 7));
        end

        // Wrapping write burst then read-back
        cmd_valid = 1'b1; we = 1'b1; addr = 8'hFE; len = 2'd3;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            ea = 8'hFE + 8'(c - 2);
            check_eq($sformatf("wrap c%0d ce", c), 32'(ce), 32'(c >= 2 && c <= 5));
            check_eq($sformatf("wrap c%0d addr_mem", c), 32'(maddr), (c >= 2 && c <= 5) ? 32'(ea) : 32'd0);
            check_eq($sformatf("wrap c%0d datai", c), 32'(mdatai), (c >= 2 && c <= 5) ? 32'(8'h60 + 8'(c - 1)) : 32'd0);
            check_eq($sformatf("wrap c%0d wr_done", c), 32'(wr_done), 32'(c == 5));
            check_eq($sformatf("wrap c%0d cmd_ready", c), 32'(cmd_ready), 32'(c == 6));
            wvalid = (c <= 4);
            wdata  = 8'h60 + 8'(c);
        end
        wvalid = 1'b0;
        cmd_valid = 1'b1; we = 1'b0; addr = 8'hFE; len = 2'd3;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            ea = 8'hFE + 8'(c - 1);
            if (c <= 4) check_eq($sformatf("wrap rd c%0d addr_mem", c), 32'(maddr), 32'(ea));
            check_eq($sformatf("wrap rd c%0d rvalid", c), 32'(rvalid), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check_eq($sformatf("wrap rd c%0d rdata", c), 32'(rdata), 32'(8'h60 + 8'(c - 2)));
            check_eq($sformatf("wrap rd c%0d rlast", c), 32'(rlast), 32'(c == 6));
        end

        // Write with a two-cycle stall between beats 1 and 2
        wv_tab = 8'h72;
        seen = 0; sent = 0;
        cmd_valid = 1'b1; we = 1'b1; addr = 8'h40; len = 2'd3;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) cmd_valid = 1'b0;
            check_eq($sformatf("stall c%0d ce", c), 32'(ce), 32'(wv_tab[c-1]));
            if (wv_tab[c-1]) begin
                check_eq($sformatf("stall c%0d addr_mem", c), 32'(maddr), 32'(8'h40 + 8'(seen)));
                check_eq($sformatf("stall c%0d datai", c), 32'(mdatai), 32'(8'h70 + 8'(seen)));
                seen++;
            end
            check_eq($sformatf("stall c%0d wr_done", c), 32'(wr_done), 32'(c == 7));
            check_eq($sformatf("stall c%0d wready", c), 32'(wready), 32'(c <= 6));
            check_eq($sformatf("stall c%0d cmd_ready", c), 32'(cmd_ready), 32'(c == 8));
            wvalid = (c <= 6) ? wv_tab[c] : 1'b0;
            if (wvalid) begin
                wdata = 8'h70 + 8'(sent);
                sent++;
            end
        end
        wvalid = 1'b0;

        // Busy: wvalid in IDLE and cmd_valid held through a read burst
        dut_write(8'h30, 2'd0, 8'h5A, 8'h00);
        wvalid = 1'b1; wdata = 8'hFF;
        tick();
        check_eq("idle wvalid ce", 32'(ce), 32'd0);
        tick();
        check_eq("idle wvalid ce2", 32'(ce), 32'd0);
        check_eq("idle wvalid cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; we = 1'b0; addr = 8'h20; len = 2'd3;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) begin
                addr = 8'h99; len = 2'd0; we = 1'b1;
            end
            check_eq($sformatf("busy c%0d ce", c), 32'(ce), 32'(c <= 4 || c == 8));
            check_eq($sformatf("busy c%0d we_mem", c), 32'(mwe), 32'd0);
            check_eq($sformatf("busy c%0d addr_mem", c), 32'(maddr),
                     (c <= 4) ? 32'(8'h1F + 8'(c)) : (c == 8) ? 32'h30 : 32'd0);
            check_eq($sformatf("busy c%0d cmd_ready", c), 32'(cmd_ready), 32'(c == 7 || c == 11));
            check_eq($sformatf("busy c%0d rvalid", c), 32'(rvalid), 32'((c >= 3 && c <= 6) || c == 10));
            check_eq($sformatf("busy c%0d rlast", c), 32'(rlast), 32'(c == 6 || c == 10));
            if (c == 10) check_eq("busy c10 rdata", 32'(rdata), 32'h5A);
            if (c == 7) begin
                addr = 8'h30; len = 2'd0; we = 1'b0;
            end
            if (c == 8) begin
                cmd_valid = 1'b0; wvalid = 1'b0;
            end
        end

        // RD_LAT=3: reset after two reads issued, then a fresh read
        cmd_valid3 = 1'b1; addr3 = 8'h50; len3 = 2'd3;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) cmd_valid3 = 1'b0;
            if (c <= 2) begin
                check_eq($sformatf("l3 c%0d ce", c), 32'(ce3), 32'd1);
                check_eq($sformatf("l3 c%0d addr_mem", c), 32'(maddr3), 32'(8'h4F + 8'(c)));
            end
            if (c == 2) reset3 = 1'b1;
        end
        check_eq("l3 rst ce", 32'(ce3), 32'd0);
        check_eq("l3 rst addr_mem", 32'(maddr3), 32'd0);
        check_eq("l3 rst rvalid", 32'(rvalid3), 32'd0);
        check_eq("l3 rst rdata", 32'(rdata3), 32'd0);
        check_eq("l3 rst cmd_ready", 32'(cmd_ready3), 32'd1);
        reset3 = 1'b0;
        nrv = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rvalid3 || ce3) nrv++;
        end
        check_eq("l3 abandoned activity", 32'(nrv), 32'd0);
        cmd_valid3 = 1'b1; addr3 = 8'h52; len3 = 2'd1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) cmd_valid3 = 1'b0;
            check_eq($sformatf("l3n c%0d ce", c), 32'(ce3), 32'(c <= 2));
            check_eq($sformatf("l3n c%0d addr_mem", c), 32'(maddr3), (c <= 2) ? 32'(8'h51 + 8'(c)) : 32'd0);
            check_eq($sformatf("l3n c%0d rvalid", c), 32'(rvalid3), 32'(c == 5 || c == 6));
            check_eq($sformatf("l3n c%0d rdata", c), 32'(rdata3),
                     (c < 5) ? 32'd0 : (c == 5) ? 32'hC3 : 32'hC4);
            check_eq($sformatf("l3n c%0d rlast", c), 32'(rlast3), 32'(c == 6));
            check_eq($sformatf("l3n c%0d cmd_ready", c), 32'(cmd_ready3), 32'(c == 7));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_ctrl_burst
`default_nettype wire

// File: doc/mem_ctrl_burst.md
Name: mem_ctrl_burst

Overview:
Parametrised single-port SRAM controller between a system-side command interface and a synchronous memory with fixed read latency. Accepts single or burst (up to 2^LEN_W beats) read/write commands with incrementing, wrapping addresses. Replaces the bidirectional system data bus with separate write and read channels. Adds explicit command-ready, write-done and read-last signalling.

Parameters:
ADDR_W, 8, address width (system and memory)
DATA_W, 8, data width
LEN_W, 2, burst length field width; beats = len_sys+1 (1..2^LEN_W)
RD_LAT, 1, memory read latency in cycles, >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid_sys  in  1  command request
cmd_ready_sys  out  1  controller can accept a command
we_sys  in  1  1=write burst, 0=read burst
addr_sys  in  ADDR_W  burst start address
len_sys  in  LEN_W  beats minus one
wvalid_sys  in  1  write beat valid
wready_sys  out  1  write beat accepted when wvalid_sys&wready_sys
wdata_sys  in  DATA_W  write beat data
wr_done_sys  out  1  one-cycle pulse: write burst complete
rvalid_sys  out  1  read beat valid (no backpressure)
rdata_sys  out  DATA_W  read beat data
rlast_sys  out  1  marks final read beat
ce_mem  out  1  memory chip enable
we_mem  out  1  memory write enable
addr_mem  out  ADDR_W  memory address
datai_mem  out  DATA_W  memory write data
datao_mem  in  DATA_W  memory read data, valid RD_LAT cycles after a read cycle on the memory pins

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 (including rdata_sys; never Z). In-flight read tags discarded; no rvalid_sys for reads issued before reset.
- Outputs to memory, rvalid/rdata/rlast, wr_done are registered. cmd_ready_sys = (state==IDLE); wready_sys = (state==WRITE), both decoded from state.
- States: IDLE, WRITE, READ, RD_DRAIN, WR_RESP.
- IDLE: on cmd_valid&cmd_ready (cycle 0), latch addr and beat count (len_sys+1), go WRITE or READ per we_sys. Memory outputs held 0.
- WRITE: each cycle with wvalid_sys: next cycle ce_mem=1, we_mem=1, addr_mem=current addr, datai_mem=wdata_sys; address += 1; count -= 1. Cycles without wvalid: ce/we/addr/datai = 0 next cycle. After last beat accepted, go WR_RESP.
- WR_RESP: wr_done_sys=1 for exactly one cycle (same cycle the last memory write is on the pins), then IDLE.
- READ: issue one read per cycle with no gaps: ce_mem=1, we_mem=0, addr_mem=addr, datai_mem=0. Push tag (valid, last) into RD_LAT-deep delay line. After last issue go RD_DRAIN; memory outputs return to 0.
- RD_DRAIN: when the tag reaching the end of the delay line has valid=1, register datao_mem into rdata_sys and set rvalid_sys=1 and rlast_sys=last. rvalid_sys for a beat is asserted RD_LAT+1 cycles after that beat's read is on the memory pins. Go IDLE in the cycle rlast_sys is asserted; cmd_ready_sys is high the following cycle.
- Latency (RD_LAT=1): read of N beats, handshake in cycle 0 -> memory reads in cycles 1..N, rvalid in cycles 3..N+2, cmd_ready high in cycle N+3.
- Address arithmetic modulo 2^ADDR_W (wrap past all-ones to 0).
- cmd_valid while busy: ignored, no latching. wvalid outside WRITE: ignored. rdata_sys holds its last value when rvalid_sys=0.
- Reset during any state: immediate return to IDLE next cycle, outputs 0; partial burst abandoned.

Decomposition:
- Package mem_ctrl_pkg: state enum (IDLE, WRITE, READ, RD_DRAIN, WR_RESP), rd_tag_t struct {valid, last}.
- Sub-module mem_rd_tag_pipe: RD_LAT-stage shift register of rd_tag_t, synchronous reset clears all stages.

Test Plan:
- Single write: addr 0x10, len 0, data 0xA5, wvalid in cycle 1 -> ce=we=1, addr_mem 0x10, datai 0xA5 in cycle 2; wr_done pulse cycle 2; cmd_ready cycle 3.
- Read burst RD_LAT=1: preload 0x20..0x23 = 11,22,33,44; read addr 0x20 len 3 -> rvalid cycles 3-6 with 0x11,0x22,0x33,0x44, rlast only cycle 6, cmd_ready cycle 7.
- Wrap: write burst addr 0xFE len 3 -> addr_mem sequence FE, FF, 00, 01; read-back matches.
- Write stalls: wvalid low for 2 cycles between beats 1 and 2 -> ce_mem low those cycles, addresses contiguous, wr_done only after beat 4.
- Busy/ignored: cmd_valid held high during read burst and wvalid high in IDLE -> no extra memory cycles, second command accepted only when cmd_ready=1.
- Reset mid-read (RD_LAT=3, after 2 reads issued) -> all outputs 0 next cycle, no rvalid ever appears for abandoned beats, new read completes correctly.
